// File: rtl/serial_seq_tx.sv
// serial_seq_tx: parallel-in, serial-out transmitter feeding the 1-bit sequence-detector link.
// Define SEQ_TX_PARITY_EN to append an even-parity bit to every word.
module serial_seq_tx #(
   parameter int WIDTH      = 16,
   parameter int GAP_CYCLES = 0,
   parameter bit IDLE_LEVEL = 1'b0,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   output logic             ready,
   output logic             outp,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT   = CW'(WIDTH - 1);
   localparam logic [CW-1:0] PENULT_BIT = CW'(WIDTH - 2);
   localparam logic [7:0]    GAP_LAST   = 8'(GAP_CYCLES - 1);

`ifdef SEQ_TX_PARITY_EN
   localparam bit HAS_PARITY = 1'b1;
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_GAP} state_t;
`else
   localparam bit HAS_PARITY = 1'b0;
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
`endif

   state_t           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_bit_cnt;
   logic [7:0]       r_gap_cnt;
   logic             r_outp;
   logic             r_done;
`ifdef SEQ_TX_PARITY_EN
   logic             r_parity;
`endif

   logic             w_ready;
   logic             w_accept;
   logic             w_first_bit;
   logic             w_next_bit;
   logic [WIDTH-1:0] w_shift_init;

   // r_done marks the final-bit cycle, which is also the back-to-back load slot.
   assign w_ready      = (r_state == S_IDLE) || (r_done && (GAP_CYCLES == 0));
   assign w_accept     = load && w_ready;
   assign w_first_bit  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
   assign w_shift_init = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
   assign w_next_bit   = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];

   assign ready = w_ready;
   assign outp  = r_outp;
   assign done  = r_done;
   assign busy  = (r_state != S_IDLE);
`ifdef SEQ_TX_PARITY_EN
   assign out_valid = (r_state == S_SHIFT) || (r_state == S_PARITY);
`else
   assign out_valid = (r_state == S_SHIFT);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_outp    <= IDLE_LEVEL;
         r_done    <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else if (w_accept) begin
         r_state   <= S_SHIFT;
         r_shift   <= w_shift_init;
         r_bit_cnt <= '0;
         r_outp    <= w_first_bit;
         r_done    <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
         r_parity  <= ^data_in;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_SHIFT: begin
               if (r_bit_cnt == LAST_BIT) begin
`ifdef SEQ_TX_PARITY_EN
                  r_state <= S_PARITY;
                  r_outp  <= r_parity;
                  r_done  <= 1'b1;
`else
                  r_outp    <= IDLE_LEVEL;
                  r_gap_cnt <= '0;
                  r_state   <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
`endif
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  r_outp    <= w_next_bit;
                  r_shift   <= MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
                  r_done    <= !HAS_PARITY && (r_bit_cnt == PENULT_BIT);
               end
            end
`ifdef SEQ_TX_PARITY_EN
            S_PARITY: begin
               r_outp    <= IDLE_LEVEL;
               r_gap_cnt <= '0;
               r_state   <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end
`endif
            S_GAP: begin
               if (r_gap_cnt == GAP_LAST) begin
                  r_state <= S_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 8'd1;
               end
            end
            default: begin
               r_outp <= IDLE_LEVEL;
            end
         endcase
      end
   end
endmodule
